// File: rtl/alu_sequencer.sv
// Control stage in front of the 4-bit ALU: accepts one op per valid/ready handshake,
// drives the ALU operands, sequences multiply via Init/Done with a timeout, and holds the result.
module alu_sequencer #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       In_valid,
    output logic       In_ready,
    input  logic [3:0] In_A,
    input  logic [3:0] In_B,
    input  logic [1:0] In_Op,
    output logic [3:0] Alu_A,
    output logic [3:0] Alu_B,
    output logic [1:0] Alu_Select,
    output logic       Alu_Init,
    input  logic [7:0] Alu_Sal,
    input  logic       Alu_Cout,
    input  logic       Alu_Done,
    output logic       Out_valid,
    input  logic       Out_ready,
    output logic [7:0] Out_Res,
    output logic       Out_Cout,
    output logic       Out_Err
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EXEC     = 2'd1;
    localparam logic [1:0] ST_WAIT_MUL = 2'd2;
    localparam logic [1:0] ST_HOLD     = 2'd3;

    localparam logic [1:0] OP_MUL   = 2'b10;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] counter;

    assign In_ready = (state == ST_IDLE);

    // NOTE: all state here is plain flops, so every register gets a reset value and only <= is used.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= ST_IDLE;
            counter    <= 8'd0;
            Alu_A      <= 4'd0;
            Alu_B      <= 4'd0;
            Alu_Select <= 2'd0;
            Alu_Init   <= 1'b0;
            Out_valid  <= 1'b0;
            Out_Res    <= 8'd0;
            Out_Cout   <= 1'b0;
            Out_Err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (In_valid) begin
                        Alu_A      <= In_A;
                        Alu_B      <= In_B;
                        Alu_Select <= In_Op;
                        Alu_Init   <= (In_Op == OP_MUL);
                        state      <= ST_EXEC;
                    end
                end

                // Done is deliberately not looked at here: it may be left over from a prior multiply.
                ST_EXEC: begin
                    if (Alu_Select == OP_MUL) begin
                        Alu_Init <= 1'b0;
                        counter  <= 8'd0;
                        state    <= ST_WAIT_MUL;
                    end else begin
                        Out_Res   <= Alu_Sal;
                        Out_Cout  <= Alu_Cout;
                        Out_Err   <= 1'b0;
                        Out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end

                // Done is tested first so that it wins over a timeout on the same edge.
                ST_WAIT_MUL: begin
                    if (Alu_Done) begin
                        Out_Res   <= Alu_Sal;
                        Out_Cout  <= Alu_Cout;
                        Out_Err   <= 1'b0;
                        Out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else if (counter == CNT_LAST) begin
                        Out_Res   <= 8'd0;
                        Out_Cout  <= 1'b0;
                        Out_Err   <= 1'b1;
                        Out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end

                ST_HOLD: begin
                    if (Out_ready) begin
                        Out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU drives Sal/Cout/Done, and each
// transaction's latency and result are predicted from the operation rules.
module tb_alu_sequencer;

    localparam int TIMEOUT = 32;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    logic       Clk;
    logic       Rst_n;
    logic       In_valid;
    logic       In_ready;
    logic [3:0] In_A;
    logic [3:0] In_B;
    logic [1:0] In_Op;
    logic [3:0] Alu_A;
    logic [3:0] Alu_B;
    logic [1:0] Alu_Select;
    logic       Alu_Init;
    logic [7:0] Alu_Sal;
    logic       Alu_Cout;
    logic       Alu_Done;
    logic       Out_valid;
    logic       Out_ready;
    logic [7:0] Out_Res;
    logic       Out_Cout;
    logic       Out_Err;

    int n_cmp;
    int n_fail;

    alu_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .In_valid(In_valid), .In_ready(In_ready),
        .In_A(In_A), .In_B(In_B), .In_Op(In_Op),
        .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_Select(Alu_Select), .Alu_Init(Alu_Init),
        .Alu_Sal(Alu_Sal), .Alu_Cout(Alu_Cout), .Alu_Done(Alu_Done),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Out_Res(Out_Res), .Out_Cout(Out_Cout), .Out_Err(Out_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // 4-bit ALU behaviour: {Cout, Sal}. Add/sub/and give a 4-bit result, mul an 8-bit product.
    function automatic logic [8:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int ai;
        int bi;
        ai = int'(a);
        bi = int'(b);
        case (op)
            OP_ADD:  return {((ai + bi) > 15), 4'd0, 4'((ai + bi) % 16)};
            OP_SUB:  return {(ai < bi), 4'd0, 4'((ai - bi + 16) % 16)};
            OP_MUL:  return {1'b0, 8'(ai * bi)};
            default: return {1'b0, 4'd0, a & b};
        endcase
    endfunction

    logic [8:0] alu_now;
    always_comb begin
        alu_now  = alu_ref(Alu_A, Alu_B, Alu_Select);
        Alu_Sal  = alu_now[7:0];
        Alu_Cout = alu_now[8];
    end

    task automatic test_reset();
        Rst_n = 1'b0;
        In_valid = 1'b0; In_A = 4'd0; In_B = 4'd0; In_Op = 2'd0;
        Alu_Done = 1'b0; Out_ready = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (In_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", In_ready); end
        n_cmp++;
        if ({Alu_A, Alu_B, Alu_Select, Alu_Init} !== 11'd0) begin
            n_fail++; $display("FAIL reset_alu: got %h want 000", {Alu_A, Alu_B, Alu_Select, Alu_Init});
        end
        n_cmp++;
        if ({Out_valid, Out_Res, Out_Cout, Out_Err} !== 11'd0) begin
            n_fail++; $display("FAIL reset_out: got %h want 000", {Out_valid, Out_Res, Out_Cout, Out_Err});
        end
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    // One full transaction. done_at = edge offset from acceptance at which Done is sampled high
    // (0 = never); stale pulses Done on the EXEC edge; hold = cycles of output backpressure.
    task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                           input int done_at, input bit stale, input int hold, input string tag);
        logic [8:0] ref_v;
        logic [7:0] exp_res;
        logic       exp_cout;
        logic       exp_err;
        int         exp_lat;
        int         lat;
        int         k;

        ref_v = alu_ref(a, b, op);
        if (op != OP_MUL) begin
            exp_lat = 1; exp_err = 1'b0; exp_res = ref_v[7:0]; exp_cout = ref_v[8];
        end else if (done_at >= 2 && done_at <= TIMEOUT + 1) begin
            exp_lat = done_at; exp_err = 1'b0; exp_res = ref_v[7:0]; exp_cout = ref_v[8];
        end else begin
            exp_lat = TIMEOUT + 1; exp_err = 1'b1; exp_res = 8'd0; exp_cout = 1'b0;
        end

        n_cmp++;
        if (In_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle_ready: got %b want 1", tag, In_ready); end

        In_A = a; In_B = b; In_Op = op; In_valid = 1'b1;
        @(negedge Clk);
        In_valid = 1'b0;
        In_A = 4'($urandom); In_B = 4'($urandom); In_Op = 2'($urandom);
        n_cmp++;
        if ({Alu_A, Alu_B, Alu_Select, Alu_Init} !== {a, b, op, op == OP_MUL}) begin
            n_fail++;
            $display("FAIL %s alu_load: got %h want %h", tag, {Alu_A, Alu_B, Alu_Select, Alu_Init}, {a, b, op, op == OP_MUL});
        end

        lat = -1;
        k = 1;
        while (lat < 0 && k <= TIMEOUT + 6) begin
            Alu_Done = ((op == OP_MUL) && (k == done_at)) || (stale && k == 1);
            @(negedge Clk);
            if (k == 1) begin
                n_cmp++;
                if (Alu_Init !== 1'b0) begin n_fail++; $display("FAIL %s init_pulse: got %b want 0", tag, Alu_Init); end
                n_cmp++;
                if (In_ready !== 1'b0) begin n_fail++; $display("FAIL %s busy_ready: got %b want 0", tag, In_ready); end
            end
            if (Out_valid === 1'b1) lat = k;
            k++;
        end
        Alu_Done = 1'b0;

        n_cmp++;
        if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); end
        n_cmp++;
        if ({Out_Res, Out_Cout, Out_Err} !== {exp_res, exp_cout, exp_err}) begin
            n_fail++;
            $display("FAIL %s result: got res=%h cout=%b err=%b want res=%h cout=%b err=%b",
                     tag, Out_Res, Out_Cout, Out_Err, exp_res, exp_cout, exp_err);
        end

        for (int i = 0; i < hold; i++) begin
            In_valid = 1'b1;
            In_A = 4'($urandom); In_B = 4'($urandom); In_Op = 2'($urandom);
            @(negedge Clk);
            n_cmp++;
            if ({Out_valid, In_ready, Out_Res, Out_Cout, Out_Err, Alu_A, Alu_B, Alu_Select} !==
                {1'b1, 1'b0, exp_res, exp_cout, exp_err, a, b, op}) begin
                n_fail++;
                $display("FAIL %s hold_%0d: got v=%b rdy=%b res=%h alu=%h%h%h want v=1 rdy=0 res=%h alu=%h%h%h",
                         tag, i, Out_valid, In_ready, Out_Res, Alu_A, Alu_B, Alu_Select, exp_res, a, b, op);
            end
        end

        In_valid = 1'b0;
        Out_ready = 1'b1;
        @(negedge Clk);
        Out_ready = 1'b0;
        n_cmp++;
        if ({Out_valid, In_ready, Out_Res, Out_Err} !== {1'b0, 1'b1, exp_res, exp_err}) begin
            n_fail++;
            $display("FAIL %s handshake: got v=%b rdy=%b res=%h err=%b want v=0 rdy=1 res=%h err=%b",
                     tag, Out_valid, In_ready, Out_Res, Out_Err, exp_res, exp_err);
        end
    endtask

    task automatic test_directed();
        run_txn(4'd9, 4'd8, OP_ADD, 0, 1'b0, 0, "add_9_8");
        run_txn(4'hC, 4'hA, OP_AND, 0, 1'b0, 3, "and_c_a");
        run_txn(4'd7, 4'd6, OP_MUL, 10, 1'b0, 0, "mul_7_6");
        run_txn(4'd3, 4'd5, OP_SUB, 0, 1'b0, 0, "sub_borrow");
        run_txn(4'd5, 4'd3, OP_SUB, 0, 1'b0, 5, "sub_backpressure");
    endtask

    task automatic test_mul_timing();
        run_txn(4'd15, 4'd15, OP_MUL, 0, 1'b0, 0, "mul_timeout");
        run_txn(4'd9, 4'd4, OP_MUL, TIMEOUT + 1, 1'b0, 0, "mul_done_at_timeout");
        run_txn(4'd2, 4'd3, OP_MUL, TIMEOUT, 1'b0, 0, "mul_done_before_timeout");
        run_txn(4'd11, 4'd13, OP_MUL, 2, 1'b0, 0, "mul_done_first");
        run_txn(4'd6, 4'd5, OP_MUL, 4, 1'b1, 1, "mul_stale_done");
        run_txn(4'd6, 4'd5, OP_MUL, 0, 1'b1, 0, "mul_stale_only");
    endtask

    task automatic test_reset_mid_mul();
        In_A = 4'd7; In_B = 4'd7; In_Op = OP_MUL; In_valid = 1'b1;
        @(negedge Clk);
        In_valid = 1'b0;
        repeat (5) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({Out_valid, Alu_Init, In_ready} !== 3'b001) begin
            n_fail++; $display("FAIL reset_mid_mul: got v=%b init=%b rdy=%b want 0 0 1", Out_valid, Alu_Init, In_ready);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (Out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_result: got %b want 0", Out_valid); end
        run_txn(4'd4, 4'd9, OP_ADD, 0, 1'b0, 0, "add_after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            int d;
            op = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 12));
            run_txn(4'($urandom), 4'($urandom), op, d, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), $sformatf("rand_%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_txn(4'(i * 5), 4'(15 - i), 2'(i), 3, 1'b0, 0, $sformatf("b2b_%0d", i));
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_directed();
        test_mul_timing();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
